usb20sr_refdes_phy_rst_seq: RTL and testbench
=============================================

# usb20sr_refdes_phy_rst_seq

Reset sequencer for the ULPI USB PHY in the USB 2.0 reference design, placed on the Avalon-MM bus alongside the reset PIO and driving the PHY reset pin and the link-core reset. It runs an automatic power-on reset sequence, and software can retrigger it:

1. Assert the PHY reset for a programmable number of cycles.
2. Wait for the PHY to release ULPI DIR, with a timeout.
3. Hold the link in reset for a settle period, then release it.

Status and completion interrupt are exposed to the Nios II CPU.

## Interface
- ASSERT_DEFAULT, 600: reset value of ASSERT_CYCLES (10 us at 60 MHz).
- SETTLE_DEFAULT, 60: reset value of SETTLE_CYCLES.
- TIMEOUT_CYCLES, 60000: maximum DIR-wait cycles before a timeout.
- CNT_W, 16: width of counters and cycle registers.
- clk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select: 0 CONTROL, 1 ASSERT_CYCLES, 2 SETTLE_CYCLES, 3 STATUS.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero wait states; unused bits 0.
- phy_dir  in  1  ULPI DIR from the PHY, already synchronised to clk.
- phy_rst  out  1  PHY reset, active-high.
- link_rst  out  1  link-core reset, active-high.
- irq  out  1  level interrupt.

## Operation
- Registers:
  - CONTROL: bit0 START (write-1 pulse, reads 0); bit1 FORCE (held phy_rst=1, link_rst=1 while set); bit2 IRQ_EN.
  - ASSERT_CYCLES and SETTLE_CYCLES: CNT_W bits, read/write. A written 0 is stored as 0 and treated as 1.
  - STATUS: bit0 BUSY; bit1 DONE (sticky); bit2 TIMEOUT (sticky); bits 6:4 state code (IDLE=0, ASSERT=1, DIRWAIT=2, SETTLE=3). Any write to STATUS clears DONE and TIMEOUT.
- States:
  - IDLE: phy_rst=FORCE, link_rst=1 unless DONE is set and FORCE is 0.
    - START with FORCE=0 → ASSERT; DONE and TIMEOUT are cleared and the counter is loaded.
  - ASSERT: phy_rst=1, link_rst=1; counts max(ASSERT_CYCLES,1) cycles → DIRWAIT.
  - DIRWAIT: phy_rst=0, link_rst=1.
    - phy_dir sampled 0 → SETTLE.
    - TIMEOUT_CYCLES elapsed with phy_dir=1 → IDLE, TIMEOUT=1, DONE=0.
  - SETTLE: phy_rst=0, link_rst=1; counts max(SETTLE_CYCLES,1) cycles → IDLE, DONE=1.
- After reset the block enters ASSERT directly, which makes the power-on sequence automatic.
- BUSY=1 in every state except IDLE.
- irq = IRQ_EN & (DONE | TIMEOUT).
- START while BUSY is ignored. Writes to ASSERT_CYCLES or SETTLE_CYCLES while BUSY update the register; the running count is unaffected and the new value applies from the next sequence.
- Setting FORCE while BUSY aborts to IDLE, leaves DONE and TIMEOUT unchanged, and drives both resets high.
- A write of START=1 together with FORCE=1 does not start a sequence; FORCE wins.
- Counters are down-counters loaded on state entry and saturate at 0; there is no wrap.
- link_rst deasserts only in IDLE with DONE=1. A timeout leaves the link held in reset.

## Timing
- Reset values:
  - Outputs: phy_rst=1, link_rst=1, irq=0, readdata follows the registers.
  - Registers: CONTROL=0, ASSERT_CYCLES=ASSERT_DEFAULT, SETTLE_CYCLES=SETTLE_DEFAULT, DONE=0, TIMEOUT=0.
  - State: ASSERT with its counter loaded.
- Outputs are registered.
- A register write takes effect at the clock edge where chipselect=1 and write_n=0.
- On START, phy_rst rises on the following edge and stays high for exactly N cycles, where N = max(ASSERT_CYCLES,1).
- DIRWAIT → SETTLE is one cycle after phy_dir is sampled low. SETTLE is exactly M cycles, where M = max(SETTLE_CYCLES,1).
- DONE, link_rst=0 and irq all change on the same edge as the SETTLE → IDLE transition.
- Timeout: TIMEOUT sets on the edge ending cycle TIMEOUT_CYCLES of DIRWAIT.
- Reset asserted mid-sequence restarts the power-on sequence from ASSERT; sticky flags are cleared.
- A simultaneous STATUS write and DONE-setting event leaves DONE=1; set wins.

## Test plan
- Power-on: release reset with phy_dir=0 and default parameters.
  - phy_rst=1 for 600 cycles, then link_rst=1 for 1 cycle of DIRWAIT plus 60 cycles of SETTLE.
  - Then link_rst=0 and STATUS=0x02.
- Software restart: write ASSERT_CYCLES=5, SETTLE_CYCLES=0, then CONTROL=0x5.
  - phy_rst high for exactly 5 cycles; SETTLE lasts 1 cycle.
  - irq=1 at completion; a STATUS write clears irq.
- DIR timeout: build with TIMEOUT_CYCLES=100, hold phy_dir=1.
  - STATUS=0x04 after exactly 100 DIRWAIT cycles; link_rst stays 1; irq follows IRQ_EN.
- START while busy: write START on the 3rd cycle of ASSERT.
  - Sequence length is unchanged and no second sequence runs.
  - An ASSERT_CYCLES write during ASSERT changes the readback only.
- FORCE abort: set FORCE=1 during SETTLE.
  - Next cycle: state IDLE, phy_rst=1, link_rst=1, DONE=0.
  - Clear FORCE, then START: normal sequence completes.
- Reset mid-DIRWAIT: assert reset for 1 cycle.
  - phy_rst=1 and state code 1 the next cycle; the full ASSERT count reruns.

Source files
------------

// File: rtl/usb20sr_refdes_phy_rst_seq_if.sv
// usb20sr_refdes_phy_rst_seq_if: Avalon-MM register port of the PHY reset sequencer
interface usb20sr_refdes_phy_rst_seq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/usb20sr_refdes_phy_rst_seq.sv
// usb20sr_refdes_phy_rst_seq: ULPI PHY / link-core reset sequencer with Avalon-MM control and status
module usb20sr_refdes_phy_rst_seq #(
    parameter int ASSERT_DEFAULT = 600,
    parameter int SETTLE_DEFAULT = 60,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int CNT_W = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    usb20sr_refdes_phy_rst_seq_if.slave        bus,
    input  logic                               phy_dir,
    output logic                               phy_rst,
    output logic                               link_rst,
    output logic                               irq
);
    typedef enum logic [1:0] {IDLE, ASSERT, DIRWAIT, SETTLE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, assert_cycles, settle_cycles;
    logic force_on, force_nx, irq_en, irq_en_nx, done, done_nx, timeout, timeout_nx;
    logic wr, wr_ctrl, clr, start, unused;
    function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] v);
        return v == '0 ? CNT_W'(1) : v;
    endfunction
    assign wr = bus.chipselect & ~bus.write_n;
    assign wr_ctrl = wr & (bus.address == 2'd0);
    assign clr = wr & (bus.address == 2'd3);
    assign force_nx = wr_ctrl ? bus.writedata[1] : force_on;
    assign irq_en_nx = wr_ctrl ? bus.writedata[2] : irq_en;
    assign start = wr_ctrl & bus.writedata[0];
    assign unused = ^bus.writedata;
    assign bus.readdata = bus.address == 2'd0 ? {29'd0, irq_en, force_on, 1'b0} :
                          bus.address == 2'd1 ? 32'(assert_cycles) :
                          bus.address == 2'd2 ? 32'(settle_cycles) :
                          {25'd0, 1'b0, state, 1'b0, timeout, done, state != IDLE};
    // FORCE overrides everything, including a START written in the same cycle
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        done_nx = done & ~clr;
        timeout_nx = timeout & ~clr;
        if (force_nx) state_nx = IDLE;
        else case (state)
            IDLE: if (start) begin
                state_nx = ASSERT;
                cnt_nx = ld(assert_cycles);
                done_nx = 1'b0;
                timeout_nx = 1'b0;
            end
            ASSERT: if (cnt <= CNT_W'(1)) begin
                state_nx = DIRWAIT;
                cnt_nx = CNT_W'(TIMEOUT_CYCLES);
            end else cnt_nx = cnt - CNT_W'(1);
            DIRWAIT: if (!phy_dir) begin
                state_nx = SETTLE;
                cnt_nx = ld(settle_cycles);
            end else if (cnt <= CNT_W'(1)) begin
                state_nx = IDLE;
                timeout_nx = 1'b1;
                done_nx = 1'b0;
            end else cnt_nx = cnt - CNT_W'(1);
            SETTLE: if (cnt <= CNT_W'(1)) begin
                state_nx = IDLE;
                done_nx = 1'b1;
            end else cnt_nx = cnt - CNT_W'(1);
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ASSERT;
            cnt <= ld(CNT_W'(ASSERT_DEFAULT));
            assert_cycles <= CNT_W'(ASSERT_DEFAULT);
            settle_cycles <= CNT_W'(SETTLE_DEFAULT);
            force_on <= 1'b0;
            irq_en <= 1'b0;
            done <= 1'b0;
            timeout <= 1'b0;
            phy_rst <= 1'b1;
            link_rst <= 1'b1;
            irq <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (wr && bus.address == 2'd1) assert_cycles <= bus.writedata[CNT_W-1:0];
            if (wr && bus.address == 2'd2) settle_cycles <= bus.writedata[CNT_W-1:0];
            force_on <= force_nx;
            irq_en <= irq_en_nx;
            done <= done_nx;
            timeout <= timeout_nx;
            phy_rst <= (state_nx == ASSERT) | ((state_nx == IDLE) & force_nx);
            link_rst <= !((state_nx == IDLE) && done_nx && !force_nx);
            irq <= irq_en_nx & (done_nx | timeout_nx);
        end
    end
endmodule

// File: tb/tb_usb20sr_refdes_phy_rst_seq.sv
// tb_usb20sr_refdes_phy_rst_seq: directed self-checking bench for the PHY reset sequencer
module tb_usb20sr_refdes_phy_rst_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic phy_dir = 1'b0;
    logic phy_rst, link_rst, irq;
    int checks = 0;
    int errors = 0;
    usb20sr_refdes_phy_rst_seq_if bus ();
    usb20sr_refdes_phy_rst_seq #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .phy_dir(phy_dir), .phy_rst(phy_rst), .link_rst(link_rst), .irq(irq)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address = a;
        bus.writedata = d;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
    endtask
    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask
    task automatic count_phy(output int n);
        n = 0;
        while (phy_rst === 1'b1 && n < 2000) begin
            tick(1);
            n++;
        end
    endtask
    task automatic count_link(output int n);
        n = 0;
        while (link_rst === 1'b1 && n < 2000) begin
            tick(1);
            n++;
        end
    endtask
    task automatic count_busy(output int n);
        logic [31:0] d;
        n = 0;
        rd(2'd3, d);
        while (d[0] === 1'b1 && n < 2000) begin
            tick(1);
            n++;
            rd(2'd3, d);
        end
    endtask
    initial begin
        logic [31:0] d;
        int n;
        bus.address = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.writedata = '0;
        tick(3);
        check("rst_phy_rst", 32'(phy_rst), 1);
        check("rst_link_rst", 32'(link_rst), 1);
        check("rst_irq", 32'(irq), 0);
        rd(2'd3, d); check("rst_status", d, 32'h11);
        rd(2'd0, d); check("rst_control", d, 0);
        rd(2'd1, d); check("rst_assert_cycles", d, 600);
        rd(2'd2, d); check("rst_settle_cycles", d, 60);
        reset = 1'b0;
        count_phy(n); check("por_phy_len", n, 600);
        count_link(n); check("por_link_len", n, 61);
        rd(2'd3, d); check("por_status", d, 32'h02);
        check("por_irq", 32'(irq), 0);
        wr(2'd1, 5);
        wr(2'd2, 0);
        rd(2'd2, d); check("settle_zero_rb", d, 0);
        wr(2'd0, 32'h5);
        check("sw_phy_rise", 32'(phy_rst), 1);
        count_phy(n); check("sw_phy_len", n, 5);
        count_link(n); check("sw_link_len", n, 2);
        check("sw_irq", 32'(irq), 1);
        rd(2'd3, d); check("sw_status", d, 32'h02);
        wr(2'd3, 0);
        check("sw_irq_clr", 32'(irq), 0);
        check("sw_link_after_clr", 32'(link_rst), 1);
        rd(2'd3, d); check("sw_status_clr", d, 0);
        phy_dir = 1'b1;
        wr(2'd0, 32'h5);
        count_phy(n); check("to_phy_len", n, 5);
        count_busy(n); check("to_dirwait_len", n, 100);
        rd(2'd3, d); check("to_status", d, 32'h04);
        check("to_link_rst", 32'(link_rst), 1);
        check("to_irq", 32'(irq), 1);
        wr(2'd0, 0);
        check("to_irq_en_off", 32'(irq), 0);
        wr(2'd3, 0);
        phy_dir = 1'b0;
        wr(2'd1, 8);
        wr(2'd2, 3);
        wr(2'd0, 32'h1);
        tick(1);
        wr(2'd0, 32'h1);
        wr(2'd1, 20);
        count_phy(n); check("busy_phy_len", n + 3, 8);
        rd(2'd1, d); check("busy_assert_rb", d, 20);
        count_link(n); check("busy_link_len", n, 4);
        tick(30);
        check("busy_no_rerun_phy", 32'(phy_rst), 0);
        rd(2'd3, d); check("busy_no_rerun_status", d, 32'h02);
        wr(2'd0, 32'h3);
        rd(2'd3, d); check("startforce_status", d, 32'h02);
        check("startforce_phy", 32'(phy_rst), 1);
        check("startforce_link", 32'(link_rst), 1);
        wr(2'd0, 0);
        check("force_clr_phy", 32'(phy_rst), 0);
        check("force_clr_link", 32'(link_rst), 0);
        wr(2'd1, 4);
        wr(2'd2, 10);
        wr(2'd0, 32'h1);
        count_phy(n); check("abort_phy_len", n, 4);
        tick(3);
        rd(2'd3, d); check("abort_in_settle", d, 32'h31);
        wr(2'd0, 32'h2);
        rd(2'd3, d); check("abort_status", d, 0);
        check("abort_phy", 32'(phy_rst), 1);
        check("abort_link", 32'(link_rst), 1);
        wr(2'd0, 32'h1);
        count_phy(n); check("abort_rerun_phy", n, 4);
        count_link(n); check("abort_rerun_link", n, 11);
        rd(2'd3, d); check("abort_rerun_status", d, 32'h02);
        phy_dir = 1'b1;
        wr(2'd0, 32'h1);
        count_phy(n);
        tick(2);
        rd(2'd3, d); check("mid_dirwait_state", d, 32'h21);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_phy", 32'(phy_rst), 1);
        check("mid_rst_link", 32'(link_rst), 1);
        rd(2'd3, d); check("mid_rst_status", d, 32'h11);
        rd(2'd1, d); check("mid_rst_assert_rb", d, 600);
        phy_dir = 1'b0;
        count_phy(n); check("mid_rst_phy_len", n, 600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
